// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-beat read/write memory responder with init sweep and stuck-at fault injection
module mem_responder #(
    parameter int data_width = 4,
    parameter int ad_width   = 4,
    parameter int bit_w      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ad_width-1:0]   req_addr,
    input  logic [data_width-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  init_done,
    input  logic                  flt_en,
    input  logic [ad_width-1:0]   flt_addr,
    input  logic [bit_w-1:0]      flt_bit,
    input  logic                  flt_val
);

    localparam int depth = 2 ** ad_width;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ad_width-1:0]   sweep_cnt;
    logic [data_width-1:0] mem [depth];
    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [data_width-1:0] rd_word;

    assign accept    = req_valid && req_ready;
    assign wr_accept = accept && req_wr;
    assign rd_accept = accept && !req_wr;

    // State register: every reset restarts the clearing sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave INIT once the last address has been cleared
    always_comb begin
        state_next = state;
        if (state == INIT && sweep_cnt == {ad_width{1'b1}}) begin
            state_next = SERVE;
        end
    end

    // Outputs: requests are refused during the sweep and while a response is stalled
    always_comb begin
        init_done = 1'b0;
        req_ready = 1'b0;
        if (state == SERVE) begin
            init_done = 1'b1;
            req_ready = !rsp_valid || rsp_ready;
        end
    end

    // Sweep counter walks every address once, wrapping back to 0 at the end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt <= '0;
        end else if (state == INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    // Storage: cleared by the sweep, otherwise written by accepted writes (never faulted)
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_accept) begin
            mem[req_addr] <= req_wdata;
        end
    end

    // Read word with the stuck-at bit forced; an index beyond the word touches nothing
    always_comb begin
        rd_word = mem[req_addr];
        for (int i = 0; i < data_width; i++) begin
            if (flt_en && flt_addr == req_addr && int'(flt_bit) == i) begin
                rd_word[i] = flt_val;
            end
        end
    end

    // Response channel: load on read accept, drop when consumed, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (rd_accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_word;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - table, directed and randomized checks of mem_responder against a reference model
module tb_mem_responder;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          flt_en = 1'b0;
    logic [AW-1:0] flt_addr = '0;
    logic [BW-1:0] flt_bit = '0;
    logic          flt_val = 1'b0;

    mem_responder #(.data_width(DW), .ad_width(AW), .bit_w(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .flt_en    (flt_en),
        .flt_addr  (flt_addr),
        .flt_bit   (flt_bit),
        .flt_val   (flt_val)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: memory contents, cycles since reset, and the pending response
    logic [DW-1:0] m_mem [16];
    int            m_cycles;
    logic          m_valid;
    logic [DW-1:0] m_data;

    function automatic logic m_done();
        return m_cycles >= 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_cycles = 0;
        m_valid  = 1'b0;
        m_data   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_init_done", 32'(init_done), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: drive inputs, compare against the model mid-cycle, advance the model at the edge
    task automatic cyc(input logic v, input logic w, input logic [3:0] a, input logic [3:0] d,
                       input logic rr, input logic fe, input logic [3:0] fa,
                       input logic [1:0] fb, input logic fv);
        logic          exp_ready;
        logic [DW-1:0] word;
        req_valid = v;  req_wr = w;  req_addr = a;  req_wdata = d;
        rsp_ready = rr; flt_en = fe; flt_addr = fa; flt_bit = fb; flt_val = fv;
        exp_ready = m_done() && (!m_valid || rr);
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("init_done", 32'(init_done), 32'(m_done()));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_data));
        @(posedge clk);
        if (!m_done()) begin
            m_cycles++;
        end else if (v && exp_ready) begin
            if (w) begin
                m_mem[a] = d;
                if (rr) m_valid = 1'b0;
            end else begin
                word = m_mem[a];
                if (fe && fa == a && int'(fb) < DW) word[fb] = fv;
                m_valid = 1'b1;
                m_data  = word;
            end
        end else if (rr) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic rr);
        cyc(1'b1, 1'b0, a, 4'h0, rr, 1'b0, 4'h0, 2'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d, input logic rr);
        cyc(1'b1, 1'b1, a, d, rr, 1'b0, 4'h0, 2'd0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0);
    endtask

    typedef struct {
        logic       v;
        logic       w;
        logic [3:0] a;
        logic [3:0] d;
        logic       rr;
        logic       fe;
        logic [3:0] fa;
        logic [1:0] fb;
        logic       fv;
        logic       ev;
        logic [3:0] ed;
    } vec_t;

    vec_t tab [16];

    initial begin
        // Expected rsp_valid / rsp_rdata just after each vector's clock edge
        tab[0]  = '{1'b1, 1'b1, 4'h3, 4'hA, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0};
        tab[1]  = '{1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'hA};
        tab[2]  = '{1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'hA};
        tab[3]  = '{1'b1, 1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'h0};
        tab[4]  = '{1'b1, 1'b1, 4'h7, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0};
        tab[5]  = '{1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 1'b1, 4'h7, 2'd2, 1'b0, 1'b1, 4'hB};
        tab[6]  = '{1'b1, 1'b0, 4'h6, 4'h0, 1'b1, 1'b1, 4'h7, 2'd2, 1'b0, 1'b1, 4'h0};
        tab[7]  = '{1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 1'b0, 4'h7, 2'd2, 1'b0, 1'b1, 4'hF};
        tab[8]  = '{1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 1'b1, 4'h7, 2'd0, 1'b0, 1'b1, 4'hE};
        tab[9]  = '{1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 1'b1, 4'h7, 2'd3, 1'b0, 1'b1, 4'h7};
        tab[10] = '{1'b1, 1'b1, 4'h0, 4'h2, 1'b1, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0, 4'h7};
        tab[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 2'd0, 1'b1, 1'b1, 4'h3};
        tab[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 4'h2};
        tab[13] = '{1'b1, 1'b1, 4'h1, 4'h5, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h2};
        tab[14] = '{1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'h5};
        tab[15] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h5};

        #1;
        do_reset();

        // Init sweep with a request held: refused for 16 cycles, then served
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 1'b1);
            if (i == 14) chk("init_done_c15", 32'(init_done), 32'(0));
        end
        chk("init_done_c17", 32'(init_done), 32'(1));
        chk("req_ready_c17", 32'(req_ready), 32'(1));
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 1'b1);
            chk("init_clear_valid", 32'(rsp_valid), 32'(1));
            chk("init_clear_data", 32'(rsp_rdata), 32'(0));
        end
        idle();

        for (int j = 0; j < 16; j++) begin
            cyc(tab[j].v, tab[j].w, tab[j].a, tab[j].d, tab[j].rr,
                tab[j].fe, tab[j].fa, tab[j].fb, tab[j].fv);
            chk($sformatf("tab%0d_valid", j), 32'(rsp_valid), 32'(tab[j].ev));
            chk($sformatf("tab%0d_rdata", j), 32'(rsp_rdata), 32'(tab[j].ed));
        end

        // Stalled response holds for three cycles, then the next request goes through
        wr(4'h5, 4'h6, 1'b1);
        rd(4'h5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rd(4'h6, 1'b0);
            chk("hold_valid", 32'(rsp_valid), 32'(1));
            chk("hold_rdata", 32'(rsp_rdata), 32'(6));
            chk("hold_ready", 32'(req_ready), 32'(0));
        end
        rd(4'h6, 1'b1);
        chk("release_valid", 32'(rsp_valid), 32'(1));
        chk("release_rdata", 32'(rsp_rdata), 32'(0));

        // Write blocked behind a stalled read response
        wr(4'h1, 4'h5, 1'b1);
        rd(4'h1, 1'b1);
        chk("raw_rdata", 32'(rsp_rdata), 32'(5));
        rd(4'h2, 1'b0);
        wr(4'h1, 4'h9, 1'b0);
        wr(4'h1, 4'h9, 1'b0);
        chk("blocked_wr_ready", 32'(req_ready), 32'(0));
        wr(4'h1, 4'h9, 1'b1);
        chk("wr_drop_valid", 32'(rsp_valid), 32'(0));
        rd(4'h1, 1'b1);
        chk("blocked_wr_data", 32'(rsp_rdata), 32'(9));

        // Reset with a response pending wipes the array
        rd(4'h3, 1'b0);
        chk("pre_rst_valid", 32'(rsp_valid), 32'(1));
        do_reset();
        for (int i = 0; i < 16; i++) idle();
        rd(4'h3, 1'b1);
        chk("post_rst_addr3", 32'(rsp_rdata), 32'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 3)), 2'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the BIST datapath: serves single-beat read/write requests from an initiator (BIST FSM or functional master) over a valid/ready request channel.
- Returns read data on a separately handshaked response channel.
- Clears the whole array after reset.
- Has a stuck-at fault-injection port so the BIST fail path can be exercised deterministically.

Parameters:
data_width, 4, data word width in bits
ad_width, 4, address width; depth = 2**ad_width words
bit_w, 2, width of flt_bit; must satisfy 2**bit_w >= data_width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_wr  input  1  1 = write, 0 = read
req_addr  input  ad_width  request address
req_wdata  input  data_width  write data
rsp_valid  output  1  read data valid
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  data_width  read data, faults applied
init_done  output  1  array clear sweep finished
flt_en  input  1  enable stuck-at fault
flt_addr  input  ad_width  faulty word address
flt_bit  input  bit_w  faulty bit index
flt_val  input  1  stuck-at value

Behaviour:
- Reset, asynchronous, active-high: state = INIT, sweep counter = 0.
  - Outputs during reset: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
  - Array contents are not reset directly; the INIT sweep clears them.
- State INIT:
  - Each cycle writes 0 to mem[sweep_cnt] and increments sweep_cnt.
  - After writing address depth-1 (counter wraps to 0), go to SERVE.
  - INIT lasts exactly 2**ad_width cycles after rst deasserts.
  - req_ready=0 throughout INIT; requests are ignored, not queued.
- State SERVE:
  - init_done=1 (registered, rises on the first SERVE cycle).
  - req_ready = !rsp_valid || rsp_ready (combinational).
  - A request is accepted when req_valid && req_ready at a rising edge.
- Write accept: mem[req_addr] <= req_wdata at that edge. No response is generated. The stored data is never faulted.
- Read accept:
  - At the accepting edge: rsp_valid <= 1 and rsp_rdata <= mem[req_addr] with the fault applied. Read latency is 1 cycle.
  - Fault applied: if flt_en && req_addr==flt_addr, bit flt_bit of the read word is replaced by flt_val. All other bits are unchanged.
  - flt_* inputs are sampled at the accepting edge only.
  - flt_bit >= data_width: no bit is modified.
- Response hold: while rsp_valid && !rsp_ready, rsp_valid and rsp_rdata hold stable and req_ready=0.
- Response drop: rsp_valid && rsp_ready && no new read accepted → rsp_valid <= 0; rsp_rdata holds its last value.
- Back-to-back: rsp_ready=1 in the same cycle as a new read accept → rsp_valid stays 1 and rsp_rdata updates. Sustained reads give one per cycle.
- Read-after-write to the same address in consecutive accepted requests returns the new data (write completes at its accept edge).
- Write accepted while a read response is pending and being accepted: allowed. rsp_valid falls, the write completes.
- Address range: full 2**ad_width range valid; no out-of-range case exists.
- Reset mid-operation: any pending response is dropped immediately (rsp_valid=0). The sweep restarts from address 0 and all prior contents are lost.

Test Plan:
1. Release rst; hold req_valid=1 → req_ready=0 and init_done=0 for exactly 16 cycles; on cycle 17 init_done=1 and req_ready=1. Read all 16 addresses → every rsp_rdata=4'h0.
2. Write addr 3 ← 4'hA, then read addr 3 with rsp_ready=1 → rsp_valid one cycle after accept, rsp_rdata=4'hA. Reads back-to-back at addrs 3,4 → 4'hA then 4'h0 on consecutive cycles.
3. Read addr 5 with rsp_ready=0 for 3 cycles → rsp_valid=1 and rsp_rdata stable for all 3 cycles, req_ready=0. Raise rsp_ready → next request accepted that same cycle.
4. Write addr 7 ← 4'hF; set flt_en=1, flt_addr=7, flt_bit=2, flt_val=0; read addr 7 → 4'hB. Read addr 6 → its stored value, unfaulted. flt_en=0, read addr 7 → 4'hF.
5. Write 4'h5 to addr 1, then read addr 1 the next cycle → 4'h5. Write 4'h9 to addr 1 during a held read response → write is blocked (req_ready=0) until rsp_ready=1.
6. Assert rst while rsp_valid=1 → rsp_valid=0 and init_done=0 immediately. After release and 16 INIT cycles, reading addr 3 (previously 4'hA) → 4'h0.
